// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks a - b - bin LSB first,
// one bit per clock, with a start/busy/done handshake and registered status flags.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_d;
  logic             w_brNext;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_resNext;

  // Full-subtractor cell on the current LSBs plus the running borrow.
  assign w_d       = r_aSr[0] ^ r_bSr[0] ^ r_br;
  assign w_brNext  = (~r_aSr[0] & r_bSr[0]) | (~(r_aSr[0] ^ r_bSr[0]) & r_br);
  assign w_resNext = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);
  assign w_accept  = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_aSr  <= '0;
      r_bSr  <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_aMsb <= 1'b0;
      r_bMsb <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_aSr  <= a;
      r_bSr  <= b;
      r_res  <= '0;
      r_br   <= bin;
      r_aMsb <= a[WIDTH-1];
      r_bMsb <= b[WIDTH-1];
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= r_cnt + CW'(1);
      r_aSr <= r_aSr >> 1;
      r_bSr <= r_bSr >> 1;
      r_res <= w_resNext;
      r_br  <= w_brNext;
    end
  end

  // Results only move on the completion edge so they stay stable while the next op runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_resNext;
      r_bout <= w_brNext;
      r_zero <= (w_resNext == '0);
      r_ovf  <= (r_aMsb ^ r_bMsb) & (w_d ^ r_aMsb);
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, handshake and reset
// behaviour, an exhaustive sweep and random operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] expDiff = '0;
  logic             expBout = 1'b0;
  logic             expZero = 1'b0;
  logic             expOvf  = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic modelOp(input int av, input int bv, input int binv);
    int raw;
    int sa;
    int sb;
    int sres;
    raw     = av - bv - binv;
    expDiff = WIDTH'((raw + 2 * MOD) % MOD);
    expBout = (av < bv + binv);
    expZero = (expDiff == 0);
    sa      = (av > SMAX) ? av - MOD : av;
    sb      = (bv > SMAX) ? bv - MOD : bv;
    sres    = sa - sb - binv;
    expOvf  = (sres > SMAX) || (sres < SMIN);
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, ".diff"}, 32'(diff), 32'(expDiff));
    checkOutput({tag, ".bout"}, 32'(bout), 32'(expBout));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(expZero));
    checkOutput({tag, ".ovf"},  32'(ovf),  32'(expOvf));
  endtask

  // One full operation; optionally scrambles operands and pulses start while busy.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic binv, input bit scramble, input string tag);
    int busyCycles;
    int guard;
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    guard = 0;
    while (!done && guard < WIDTH + 3) begin
      if (busy) busyCycles++;
      checkOutput({tag, ".holdDiff"}, 32'(diff), 32'(expDiff));
      checkOutput({tag, ".holdBout"}, 32'(bout), 32'(expBout));
      if (scramble) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        bin = 1'($urandom);
        start = (guard == 0);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(WIDTH));
    checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
    modelOp(int'(av), int'(bv), int'(binv));
    checkResults(tag);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, ".noRequeue"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int doneAt[$];
    int guard;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkResults("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(4'd9, 4'd3, 1'b0, 1'b0, "basic");
    applyStimulus(4'd3, 4'd9, 1'b0, 1'b0, "borrow");
    applyStimulus(4'd5, 4'd5, 1'b1, 1'b0, "borrowIn");
    applyStimulus(4'd5, 4'd5, 1'b0, 1'b0, "zero");
    applyStimulus(4'd7, 4'd8, 1'b0, 1'b0, "ovfPos");
    applyStimulus(4'd8, 4'd1, 1'b0, 1'b0, "ovfNeg");
    applyStimulus(4'd9, 4'd3, 1'b0, 1'b1, "midChange");

    $display("[TB] continuous start");
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 5 * (WIDTH + 1) + 2; cyc++) begin
      @(negedge clk);
      if (done) doneAt.push_back(cyc);
      if (busy && done) checkOutput("doneWhileBusy", 32'd1, 32'd0);
    end
    start = 1'b0;
    checkOutput("streamCount", 32'(doneAt.size() >= 4), 32'd1);
    for (int i = 1; i < doneAt.size(); i++)
      checkOutput("streamGap", 32'(doneAt[i] - doneAt[i-1]), 32'(WIDTH + 1));
    guard = 0;
    while ((busy || done) && guard < 2 * WIDTH) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("streamDrain", 32'(busy), 32'd0);
    modelOp(9, 3, 0);
    checkResults("stream");

    $display("[TB] reset mid-operation");
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    expDiff = '0; expBout = 1'b0; expZero = 1'b0; expOvf = 1'b0;
    checkResults("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 2 * WIDTH + 2; cyc++) begin
      @(negedge clk);
      checkOutput("postReset.done", 32'(done), 32'd0);
      checkOutput("postReset.busy", 32'(busy), 32'd0);
    end
    checkResults("postReset");

    $display("[TB] exhaustive sweep");
    for (int av = 0; av < MOD; av++)
      for (int bv = 0; bv < MOD; bv++)
        for (int bi = 0; bi < 2; bi++)
          applyStimulus(WIDTH'(av), WIDTH'(bv), 1'(bi), 1'($urandom), "sweep");

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++)
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
